// File: rtl/reg_file_wb_ctrlr.sv
// reg_file_wb_ctrlr
// Pipelined register-file write-address controller. It decodes the write
// enable and destination register of the instruction at issue, then carries
// that write through DEPTH stages to the register file write port. Any
// instruction at issue that reads a register with a write still in flight is
// held with o_stall. i_flush kills every entry that has not yet reached the
// output stage.
//
// Ports:
//   clock        rising-edge system clock
//   reset        asynchronous, active-low reset
//   i_valid      instruction present at issue
//   i_alu_op     ALU-class instruction
//   i_imm_op     immediate form, destination is rt
//   i_mem_op     memory-class instruction
//   i_write_op   with i_mem_op: store, no register write
//   i_link_op    link write to LINK_REG
//   i_rs         source register 1
//   i_rt         source / destination register
//   i_rd         destination register for R-type
//   i_flush      kill all entries not yet at the output stage
//   o_stall      issue blocked by a read-after-write hazard
//   o_w_en       registered register file write enable
//   o_w_addr     registered register file write address (0 when idle)
//   o_busy       at least one stage holds a valid entry
module reg_file_wb_ctrlr #(
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 3,
    parameter int LINK_REG = 31
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_valid,
    input  logic              i_alu_op,
    input  logic              i_imm_op,
    input  logic              i_mem_op,
    input  logic              i_write_op,
    input  logic              i_link_op,
    input  logic [ADDR_W-1:0] i_rs,
    input  logic [ADDR_W-1:0] i_rt,
    input  logic [ADDR_W-1:0] i_rd,
    input  logic              i_flush,
    output logic              o_stall,
    output logic              o_w_en,
    output logic [ADDR_W-1:0] o_w_addr,
    output logic              o_busy
);

    localparam logic [ADDR_W-1:0] LinkAddr = ADDR_W'(LINK_REG);

    logic [DEPTH-1:0]  stageValid_q, stageValid_d;
    logic [DEPTH-1:0]  stageWen_q, stageWen_d;
    logic [ADDR_W-1:0] stageAddr_q [DEPTH];
    logic [ADDR_W-1:0] stageAddr_d [DEPTH];

    logic              decWen;
    logic [ADDR_W-1:0] decAddr;
    logic              rsRead, rtRead;
    logic              pendingRs, pendingRt;
    logic              accept;

    // Destination decode at issue. Link wins over everything, then the
    // rt-destination forms (loads and immediates), then R-type rd. A
    // destination of register 0 is never written, so it also kills the
    // write enable and therefore never enters the scoreboard.
    always_comb begin
        decAddr = '0;
        if (i_link_op) begin
            decAddr = LinkAddr;
        end else if (i_mem_op || (i_alu_op && i_imm_op)) begin
            decAddr = i_rt;
        end else if (i_alu_op) begin
            decAddr = i_rd;
        end
        decWen = (i_alu_op | (i_mem_op & ~i_write_op) | i_link_op) & (decAddr != '0);
    end

    assign rsRead = i_alu_op | i_mem_op;
    assign rtRead = (i_alu_op & ~i_imm_op) | (i_mem_op & i_write_op);

    // Scoreboard lookup derived straight from the pipeline contents, output
    // stage included. Since nothing is counted, several in-flight writes to
    // the same register simply keep it pending until the last one leaves.
    always_comb begin
        pendingRs = 1'b0;
        pendingRt = 1'b0;
        for (int s = 0; s < DEPTH; s++) begin
            if (stageValid_q[s] && stageWen_q[s] && (stageAddr_q[s] == i_rs)) begin
                pendingRs = 1'b1;
            end
            if (stageValid_q[s] && stageWen_q[s] && (stageAddr_q[s] == i_rt)) begin
                pendingRt = 1'b1;
            end
        end
    end

    assign o_stall = i_valid & ~i_flush &
                     ((rsRead & (i_rs != '0) & pendingRs) |
                      (rtRead & (i_rt != '0) & pendingRt));

    assign accept = i_valid & ~o_stall & ~i_flush;

    // Next pipeline contents. Normally everything shifts one stage toward
    // writeback with the issue slot (entry or bubble) entering stage 0. A
    // flush turns every stage into a bubble; the entry currently on the
    // output is still sampled by the register file on this same edge.
    // Bubbles carry wen=0 and addr=0 so the output needs no extra gating.
    always_comb begin
        stageValid_d = '0;
        stageWen_d   = '0;
        for (int s = 0; s < DEPTH; s++) begin
            stageAddr_d[s] = '0;
        end
        if (!i_flush) begin
            stageValid_d[0] = accept;
            stageWen_d[0]   = accept & decWen;
            stageAddr_d[0]  = accept ? decAddr : '0;
            for (int s = 1; s < DEPTH; s++) begin
                stageValid_d[s] = stageValid_q[s-1];
                stageWen_d[s]   = stageWen_q[s-1];
                stageAddr_d[s]  = stageAddr_q[s-1];
            end
        end
    end

    // Pipeline registers. Reset empties every stage at once, discarding any
    // in-flight writes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stageValid_q <= '0;
            stageWen_q   <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                stageAddr_q[s] <= '0;
            end
        end else begin
            stageValid_q <= stageValid_d;
            stageWen_q   <= stageWen_d;
            for (int s = 0; s < DEPTH; s++) begin
                stageAddr_q[s] <= stageAddr_d[s];
            end
        end
    end

    assign o_w_en   = stageWen_q[DEPTH-1];
    assign o_w_addr = stageAddr_q[DEPTH-1];
    assign o_busy   = |stageValid_q;

endmodule

// File: tb/tb_reg_file_wb_ctrlr.sv
// tb_reg_file_wb_ctrlr
// Directed bench for reg_file_wb_ctrlr with DEPTH=3, LINK_REG=31. Each
// scenario presents instructions cycle by cycle and compares o_w_en,
// o_w_addr, o_busy and o_stall against hand-computed values, 1 time unit
// after the rising edge.
module tb_reg_file_wb_ctrlr;

    logic       clock = 1'b0;
    logic       reset;
    logic       i_valid, i_alu_op, i_imm_op, i_mem_op, i_write_op, i_link_op;
    logic [4:0] i_rs, i_rt, i_rd;
    logic       i_flush;
    logic       o_stall, o_w_en, o_busy;
    logic [4:0] o_w_addr;

    int testsRun    = 0;
    int testsFailed = 0;

    reg_file_wb_ctrlr #(.ADDR_W(5), .DEPTH(3), .LINK_REG(31)) dut (
        .clock      (clock),
        .reset      (reset),
        .i_valid    (i_valid),
        .i_alu_op   (i_alu_op),
        .i_imm_op   (i_imm_op),
        .i_mem_op   (i_mem_op),
        .i_write_op (i_write_op),
        .i_link_op  (i_link_op),
        .i_rs       (i_rs),
        .i_rt       (i_rt),
        .i_rd       (i_rd),
        .i_flush    (i_flush),
        .o_stall    (o_stall),
        .o_w_en     (o_w_en),
        .o_w_addr   (o_w_addr),
        .o_busy     (o_busy)
    );

    always #5 clock = ~clock;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drives the issue-side inputs; the settle delay lets o_stall respond.
    task automatic applyStimulus(input logic v, input logic alu, input logic imm, input logic mem,
                                 input logic wr, input logic link, input int rs, input int rt,
                                 input int rd, input logic flush);
        i_valid    = v;
        i_alu_op   = alu;
        i_imm_op   = imm;
        i_mem_op   = mem;
        i_write_op = wr;
        i_link_op  = link;
        i_rs       = 5'(rs);
        i_rt       = 5'(rt);
        i_rd       = 5'(rd);
        i_flush    = flush;
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkWrite(input string tag, input logic en, input int addr);
        checkOutput({tag, ".w_en"}, 32'(o_w_en), 32'(en));
        checkOutput({tag, ".w_addr"}, 32'(o_w_addr), 32'(addr));
    endtask

    initial begin
        reset = 1'b0;
        idle();

        // Reset state, with a valid reader present: scoreboard is empty.
        applyStimulus(1, 1, 0, 0, 0, 0, 1, 2, 8, 0);
        tick();
        tick();
        checkWrite("rst", 0, 0);
        checkOutput("rst.busy", 32'(o_busy), 0);
        checkOutput("rst.stall", 32'(o_stall), 0);
        idle();
        #2 reset = 1'b1;

        // R-type add rd=8: visible in the cycle after the third edge.
        applyStimulus(1, 1, 0, 0, 0, 0, 1, 2, 8, 0);
        checkOutput("add.stall", 32'(o_stall), 0);
        tick();
        idle();
        checkOutput("add.busy1", 32'(o_busy), 1);
        checkWrite("add.e1", 0, 0);
        tick();
        checkOutput("add.busy2", 32'(o_busy), 1);
        checkWrite("add.e2", 0, 0);
        tick();
        checkOutput("add.busy3", 32'(o_busy), 1);
        checkWrite("add.e3", 1, 8);
        tick();
        checkOutput("add.busy4", 32'(o_busy), 0);
        checkWrite("add.e4", 0, 0);

        // Store rt=9: occupies the pipe but never writes.
        applyStimulus(1, 0, 0, 1, 1, 0, 1, 9, 0, 0);
        tick();
        idle();
        tick();
        checkOutput("st.w_en2", 32'(o_w_en), 0);
        tick();
        checkOutput("st.w_en3", 32'(o_w_en), 0);
        checkOutput("st.busy3", 32'(o_busy), 1);
        tick();
        checkOutput("st.busy4", 32'(o_busy), 0);

        // Destination select: addi rt=5, load rt=6, jal, R-type rd=0, R-type rd=11 reading r0.
        applyStimulus(1, 1, 1, 0, 0, 0, 1, 5, 0, 0);
        tick();
        applyStimulus(1, 0, 0, 1, 0, 0, 1, 6, 0, 0);
        checkOutput("ld.stall", 32'(o_stall), 0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        tick();
        checkWrite("addi", 1, 5);
        applyStimulus(1, 1, 0, 0, 0, 0, 1, 2, 0, 0);
        tick();
        checkWrite("load", 1, 6);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 11, 0);
        checkOutput("r0.stall", 32'(o_stall), 0);
        tick();
        idle();
        checkWrite("jal", 1, 31);
        tick();
        checkOutput("rd0.w_en", 32'(o_w_en), 0);
        tick();
        checkWrite("rd11", 1, 11);
        tick();
        tick();
        checkOutput("sel.busy", 32'(o_busy), 0);

        // RAW hazard: add rd=8 then sub rd=8 rs=8 stalls three cycles.
        applyStimulus(1, 1, 0, 0, 0, 0, 1, 2, 8, 0);
        tick();
        applyStimulus(1, 1, 0, 0, 0, 0, 8, 3, 8, 0);
        checkOutput("raw.stall1", 32'(o_stall), 1);
        tick();
        checkOutput("raw.stall2", 32'(o_stall), 1);
        tick();
        checkOutput("raw.stall3", 32'(o_stall), 1);
        checkWrite("raw.add", 1, 8);
        tick();
        checkOutput("raw.release", 32'(o_stall), 0);
        checkWrite("raw.gap", 0, 0);
        tick();
        applyStimulus(1, 1, 1, 0, 0, 0, 1, 8, 0, 0);
        checkOutput("raw.addi_nostall", 32'(o_stall), 0);
        tick();
        idle();
        tick();
        checkWrite("raw.sub", 1, 8);
        tick();
        checkWrite("raw.addi", 1, 8);
        tick();

        // Back-to-back writes to r10; a reader of r10 waits for both.
        applyStimulus(1, 1, 0, 0, 0, 0, 1, 2, 10, 0);
        tick();
        applyStimulus(1, 1, 0, 0, 0, 0, 1, 2, 10, 0);
        tick();
        applyStimulus(1, 1, 0, 0, 0, 0, 10, 0, 13, 0);
        checkOutput("b2b.stall0", 32'(o_stall), 1);
        tick();
        checkWrite("b2b.first", 1, 10);
        checkOutput("b2b.stall1", 32'(o_stall), 1);
        tick();
        checkWrite("b2b.second", 1, 10);
        checkOutput("b2b.stall2", 32'(o_stall), 1);
        tick();
        checkWrite("b2b.done", 0, 0);
        checkOutput("b2b.stall3", 32'(o_stall), 0);
        tick();
        idle();
        tick();
        tick();
        checkWrite("b2b.rd13", 1, 13);
        tick();

        // Flush with the write to 3 at the output stage.
        applyStimulus(1, 1, 1, 0, 0, 0, 1, 3, 0, 0);
        tick();
        applyStimulus(1, 1, 1, 0, 0, 0, 1, 4, 0, 0);
        tick();
        applyStimulus(1, 1, 1, 0, 0, 0, 1, 5, 0, 0);
        tick();
        applyStimulus(1, 1, 0, 0, 0, 0, 4, 0, 14, 1);
        checkWrite("fl.commit", 1, 3);
        checkOutput("fl.stall", 32'(o_stall), 0);
        tick();
        idle();
        checkOutput("fl.busy", 32'(o_busy), 0);
        checkWrite("fl.after", 0, 0);
        tick();
        tick();
        checkOutput("fl.noissue", 32'(o_w_en), 0);

        // Async reset with two valid entries, one on the output.
        applyStimulus(1, 1, 0, 0, 0, 0, 1, 2, 20, 0);
        tick();
        applyStimulus(1, 1, 0, 0, 0, 0, 1, 2, 21, 0);
        tick();
        idle();
        tick();
        checkWrite("ar.pre", 1, 20);
        #2 reset = 1'b0;
        #1;
        checkWrite("ar.now", 0, 0);
        checkOutput("ar.busy", 32'(o_busy), 0);
        #2 reset = 1'b1;
        applyStimulus(1, 1, 0, 0, 0, 0, 1, 2, 7, 0);
        tick();
        idle();
        checkOutput("ar.busy_new", 32'(o_busy), 1);
        checkOutput("ar.no21", 32'(o_w_en), 0);
        tick();
        checkOutput("ar.no21b", 32'(o_w_en), 0);
        tick();
        checkWrite("ar.rd7", 1, 7);
        tick();
        checkOutput("ar.end_busy", 32'(o_busy), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/reg_file_wb_ctrlr.md
Name: reg_file_wb_ctrlr

Overview:
- Parametrised, pipelined successor to the combinational register-file write-address controller.
- Decodes write enable and destination register (rd, rt or link register) at issue.
- Carries the decoded write through DEPTH stages to writeback.
- Keeps a scoreboard of in-flight destinations, raising a stall when an issuing instruction reads a pending register.
- Supports flush of younger in-flight writes; sits between decode and the register file write port.

Parameters:
- ADDR_W, 5, register address width (register count = 2**ADDR_W).
- DEPTH, 3, stages from issue to writeback (min 1). Stage DEPTH-1 is the output register.
- LINK_REG, 31, destination for link (jal-type) writes.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_valid  in  1  instruction present at issue.
- i_alu_op  in  1  ALU-class instruction.
- i_imm_op  in  1  immediate form (destination rt).
- i_mem_op  in  1  memory-class instruction.
- i_write_op  in  1  with i_mem_op: store (no register write).
- i_link_op  in  1  link write to LINK_REG.
- i_rs  in  ADDR_W  source register 1.
- i_rt  in  ADDR_W  source / destination register.
- i_rd  in  ADDR_W  destination register (R-type).
- i_flush  in  1  kill all not-yet-output entries.
- o_stall  out  1  issue blocked by hazard.
- o_w_en  out  1  register file write enable, registered.
- o_w_addr  out  ADDR_W  register file write address, registered.
- o_busy  out  1  any stage holds a valid entry.

Behaviour:
- Decode (combinational, at issue):
  - wen = i_alu_op | (i_mem_op & ~i_write_op) | i_link_op.
  - waddr priority: i_link_op -> LINK_REG; else i_mem_op or (i_alu_op & i_imm_op) -> i_rt; else i_alu_op -> i_rd; else 0.
  - No X outputs.
  - waddr == 0 forces wen = 0 ($0 never written).
- Source usage:
  - rs is read for any alu or mem op.
  - rt is read for (i_alu_op & ~i_imm_op) or (i_mem_op & i_write_op).
  - Register 0 is never a hazard.
- Scoreboard:
  - pending[r] = OR over all DEPTH stages of (valid & wen & addr == r), including the output stage.
  - Derived from pipeline contents; no separate counters. Multiple in-flight writes to the same register are therefore safe.
- o_stall (combinational) = i_valid & ~i_flush & (rs read & pending[i_rs] | rt read & pending[i_rt]).
- Issue:
  - An entry is accepted when i_valid & ~o_stall & ~i_flush.
  - Otherwise a bubble (valid = 0) enters stage 0.
- Pipeline:
  - Every cycle each stage shifts to the next; there is no back-pressure from writeback.
  - An accepted write appears on o_w_en/o_w_addr exactly DEPTH cycles after the issue edge.
  - For DEPTH = 1, stage 0 is the output register.
  - o_w_en = output-stage valid & wen. o_w_addr holds the output-stage addr and is 0 when not valid.
- Flush:
  - At the next edge, stages 0..DEPTH-2 and the incoming issue slot become bubbles, and a bubble is shifted into the output stage.
  - The entry already presented on o_w_en during the flush cycle still commits, since the register file samples it on that edge.
  - o_stall is 0 during a flush cycle.
- Simultaneous flush and stall: flush wins; nothing is issued.
- Hazard release: a stalled instruction issues in the cycle after its producer leaves the output stage.
- o_busy = OR of all stage valid bits.
- Reset (reset = 0, asynchronous):
  - All stages are invalid; o_w_en = 0, o_w_addr = 0, o_busy = 0.
  - o_stall = 0 because the scoreboard is empty.
  - Reset asserted mid-operation discards all in-flight writes immediately.
  - The first issue is accepted at the first rising edge after reset deasserts.

Test Plan (DEPTH=3, LINK_REG=31):
- R-type add: rd=8, rs=1, rt=2, issued at edge 0 -> o_w_en=1, o_w_addr=8 in the cycle after edge 3; o_busy=1 for 3 cycles. Store (mem+write, rt=9) -> o_w_en never asserted.
- Destination select: addi rt=5 -> addr 5; load rt=6 -> addr 6; jal -> addr 31; R-type with rd=0 -> o_w_en stays 0 and no stall is created.
- RAW hazard: add rd=8, then sub rs=8 next cycle -> o_stall=1 for 3 cycles; sub issues when the add leaves the output stage and writes 8 three cycles later. A second instruction using rt=8 under addi (rt not read) -> no stall.
- Back-to-back writes to r10 at issue cycles 0 and 1 -> two o_w_en pulses to addr 10 on consecutive cycles; pending[10] clears only after the second.
- Flush: issue writes to 3, 4, 5 on consecutive cycles; assert i_flush with the write to 3 at output -> only the write to 3 commits, o_busy=0 the next cycle, o_stall=0 during the flush.
- Async reset mid-pipeline: reset low between edges while 2 entries are valid -> o_w_en=0, o_w_addr=0, o_busy=0 immediately; after release, a new add rd=7 writes 7 after 3 edges.
